// File: rtl/ecc_error_logger_if.sv
// ECC error logger bus bundle: event strobe, clear, and status-read handshake.
// master drives events and read requests; slave is the logger itself.
interface ecc_error_logger_if #(
   parameter int REGDIRSIZE = 5
);
   logic                  event_valid_i;
   logic [1:0]            result_i;
   logic [REGDIRSIZE-1:0] register_i;
   logic                  clr_i;
   logic                  rd_valid_i;
   logic [1:0]            rd_adr_i;
   logic [31:0]           rd_data_o;
   logic                  rd_ready_o;
   logic                  irq_o;

   modport master (
      output event_valid_i, result_i, register_i, clr_i, rd_valid_i, rd_adr_i,
      input  rd_data_o, rd_ready_o, irq_o
   );

   modport slave (
      input  event_valid_i, result_i, register_i, clr_i, rd_valid_i, rd_adr_i,
      output rd_data_o, rd_ready_o, irq_o
   );
endinterface

// File: rtl/ecc_error_logger.sv
// ECC error logger: saturating corrected/uncorrectable counters, a small
// event FIFO of {uncorr, register} with sticky overflow, and a one-cycle
// latency status-read port.
// Optional feature: define ECC_LOG_IRQ_EN to get a registered level
// interrupt irq_o = (uncorr_cnt != 0) | ovf; otherwise irq_o is tied to 0.
//
// Read FSM states:
//   state  | meaning
//   S_IDLE | waiting for rd_valid_i; latches read data on request
//   S_RESP | rd_ready_o high for one cycle, rd_data_o valid, FIFO pop here
//   S_WAIT | request acknowledged; wait for rd_valid_i to drop
module ecc_error_logger #(
   parameter int REGDIRSIZE  = 5,
   parameter int COUNTERSIZE = 32,
   parameter int FIFO_DEPTH  = 4
) (
   input logic             clk_i,
   input logic             rst_ni,
   ecc_error_logger_if.slave bus
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = REGDIRSIZE + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RESP = 2'd1,
      S_WAIT = 2'd2
   } rd_state_t;

   localparam logic [COUNTERSIZE-1:0] CNT_MAX = {COUNTERSIZE{1'b1}};

   logic [COUNTERSIZE-1:0] corr_cnt;
   logic [COUNTERSIZE-1:0] uncorr_cnt;
   logic                   ovf;

   logic [EW-1:0]          mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [CW-1:0]          fifo_cnt;
   logic                   push_pend;
   logic [EW-1:0]          push_entry;

   rd_state_t              state;
   logic                   pop_armed;
   logic                   rd_ready;
   logic [31:0]            rd_data;

   logic                   is_corr;
   logic                   is_uncorr;
   logic                   full;
   logic                   empty;
   logic                   pop;
   logic                   do_push;
   logic [EW-1:0]          head_entry;
   logic [31:0]            head_word;
   logic [31:0]            status_word;
   logic [31:0]            rd_mux;

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign is_corr   = bus.event_valid_i && (bus.result_i == 2'b01);
   assign is_uncorr = bus.event_valid_i && bus.result_i[1];

   assign full  = (fifo_cnt == CW'(FIFO_DEPTH));
   assign empty = (fifo_cnt == '0);

   // pop_armed was decided when the data was latched, so the popped entry
   // is exactly the one that was returned
   assign pop     = (state == S_RESP) && pop_armed;
   // a full FIFO still accepts a push when a pop frees a slot on the same edge
   assign do_push = push_pend && (!full || pop);

   assign head_entry = mem[rd_ptr];

   // read data words for the status and FIFO-head addresses
   always_comb begin
      head_word                   = '0;
      head_word[31]               = head_entry[EW-1];
      head_word[REGDIRSIZE-1:0]   = head_entry[REGDIRSIZE-1:0];
      status_word                 = '0;
      status_word[31]             = ovf;
      status_word[15:8]           = 8'(fifo_cnt);
      status_word[1]              = full;
      status_word[0]              = empty;
   end

   // address decode for status reads
   always_comb begin
      rd_mux = '0;
      case (bus.rd_adr_i)
         2'd0:    rd_mux = 32'(corr_cnt);
         2'd1:    rd_mux = 32'(uncorr_cnt);
         2'd2:    rd_mux = status_word;
         default: rd_mux = empty ? 32'h0 : head_word;
      endcase
   end

   // error counters and the one-cycle push stage; clear discards the event
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
         push_pend  <= 1'b0;
         push_entry <= '0;
      end else if (bus.clr_i) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
         push_pend  <= 1'b0;
      end else begin
         if (is_corr && (corr_cnt != CNT_MAX))
            corr_cnt <= corr_cnt + 1'b1;
         if (is_uncorr && (uncorr_cnt != CNT_MAX))
            uncorr_cnt <= uncorr_cnt + 1'b1;
         push_pend  <= is_corr || is_uncorr;
         push_entry <= {bus.result_i[1], bus.register_i};
      end
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         ovf      <= 1'b0;
      end else if (bus.clr_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= ptr_next(wr_ptr);
         if (pop)
            rd_ptr <= ptr_next(rd_ptr);
         if (push_pend && full && !pop)
            ovf <= 1'b1;
         case ({do_push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // FIFO storage, no reset needed since occupancy gates every read
   always_ff @(posedge clk_i) begin
      if (do_push && !bus.clr_i)
         mem[wr_ptr] <= push_entry;
   end

   // read handshake FSM with registered acknowledge and data
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= S_IDLE;
         rd_ready  <= 1'b0;
         rd_data   <= '0;
         pop_armed <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.rd_valid_i) begin
                  state     <= S_RESP;
                  rd_ready  <= 1'b1;
                  rd_data   <= rd_mux;
                  pop_armed <= (bus.rd_adr_i == 2'd3) && !empty;
               end
            end
            S_RESP: begin
               state     <= S_WAIT;
               rd_ready  <= 1'b0;
               rd_data   <= '0;
               pop_armed <= 1'b0;
            end
            S_WAIT: begin
               if (!bus.rd_valid_i)
                  state <= S_IDLE;
            end
            default: begin
               state     <= S_IDLE;
               rd_ready  <= 1'b0;
               rd_data   <= '0;
               pop_armed <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_ready_o = rd_ready;
   assign bus.rd_data_o  = rd_data;

`ifdef ECC_LOG_IRQ_EN
   logic irq_q;

   // level interrupt from the registered counter/overflow state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         irq_q <= 1'b0;
      else
         irq_q <= (uncorr_cnt != '0) || ovf;
   end

   assign bus.irq_o = irq_q;
`else
   assign bus.irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_error_logger.sv
// Directed bench for ecc_error_logger with a read-data scoreboard and a
// small reference model of counters, FIFO and overflow.
module tb_ecc_error_logger;

   localparam int RDS   = 5;
   localparam int CSZ   = 4;
   localparam int DEPTH = 4;
   localparam int CMAX  = (1 << CSZ) - 1;

   logic clk;
   logic rst_n;

   ecc_error_logger_if #(.REGDIRSIZE(RDS)) bus ();

   ecc_error_logger #(
      .REGDIRSIZE (RDS),
      .COUNTERSIZE(CSZ),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   logic [31:0] exp_q[$];
   logic [31:0] m_fifo[$];
   int          m_corr;
   int          m_uncorr;
   bit          m_ovf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      m_corr   = 0;
      m_uncorr = 0;
      m_ovf    = 1'b0;
      m_fifo.delete();
   endfunction

   function automatic void model_event(input logic [1:0] res, input logic [RDS-1:0] rg);
      logic [31:0] w;
      if (res == 2'b01 && m_corr < CMAX) m_corr++;
      if (res[1] && m_uncorr < CMAX) m_uncorr++;
      if (res != 2'b00) begin
         w = '0;
         w[31] = res[1];
         w[RDS-1:0] = rg;
         if (m_fifo.size() == DEPTH) m_ovf = 1'b1;
         else m_fifo.push_back(w);
      end
   endfunction

   function automatic logic [31:0] model_status();
      logic [31:0] w;
      w = '0;
      w[31]   = m_ovf;
      w[15:8] = 8'(m_fifo.size());
      w[1]    = (m_fifo.size() == DEPTH);
      w[0]    = (m_fifo.size() == 0);
      return w;
   endfunction

   function automatic logic [31:0] model_read(input logic [1:0] adr);
      case (adr)
         2'd0: return 32'(m_corr);
         2'd1: return 32'(m_uncorr);
         2'd2: return model_status();
         default: begin
            if (m_fifo.size() == 0) return 32'h0;
            return m_fifo.pop_front();
         end
      endcase
   endfunction

   function automatic logic exp_irq();
`ifdef ECC_LOG_IRQ_EN
      return (m_uncorr != 0) || m_ovf;
`else
      return 1'b0;
`endif
   endfunction

   task automatic send_event(input logic [1:0] res, input logic [RDS-1:0] rg);
      model_event(res, rg);
      @(negedge clk);
      bus.event_valid_i = 1'b1;
      bus.result_i      = res;
      bus.register_i    = rg;
      @(negedge clk);
      bus.event_valid_i = 1'b0;
   endtask

   task automatic do_clr();
      @(negedge clk);
      bus.clr_i = 1'b1;
      @(negedge clk);
      bus.clr_i = 1'b0;
      model_clear();
   endtask

   // one read request held for 'hold' cycles, optionally with an event
   // strobe driven in the same cycle as the request
   task automatic do_read(input logic [1:0] adr, input int hold, input bit with_evt,
                          input logic [1:0] eres, input logic [RDS-1:0] ereg);
      int acks;
      int first;
      exp_q.push_back(model_read(adr));
      if (with_evt) model_event(eres, ereg);
      @(negedge clk);
      bus.rd_valid_i = 1'b1;
      bus.rd_adr_i   = adr;
      if (with_evt) begin
         bus.event_valid_i = 1'b1;
         bus.result_i      = eres;
         bus.register_i    = ereg;
      end
      acks  = 0;
      first = 0;
      for (int c = 1; c <= hold + 3; c++) begin
         @(negedge clk);
         if (c == 1) bus.event_valid_i = 1'b0;
         if (bus.rd_ready_o === 1'b1) begin
            acks++;
            if (first == 0) first = c;
            if (exp_q.size() > 0)
               check($sformatf("rd_data adr%0d", adr), bus.rd_data_o, exp_q.pop_front());
         end else begin
            check("rd_data zero outside resp", bus.rd_data_o, 32'h0);
         end
         if (c == hold) bus.rd_valid_i = 1'b0;
      end
      check("ack count", 32'(acks), 32'd1);
      check("ack latency", 32'(first), 32'd1);
      exp_q.delete();
   endtask

   initial begin
      rst_n             = 1'b0;
      bus.event_valid_i = 1'b0;
      bus.result_i      = 2'b00;
      bus.register_i    = '0;
      bus.clr_i         = 1'b0;
      bus.rd_valid_i    = 1'b0;
      bus.rd_adr_i      = 2'd0;
      model_clear();

      // reset state
      repeat (3) @(negedge clk);
      check("reset rd_ready", 32'(bus.rd_ready_o), 32'd0);
      check("reset rd_data", bus.rd_data_o, 32'h0);
      check("reset irq", 32'(bus.irq_o), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post reset rd_ready", 32'(bus.rd_ready_o), 32'd0);

      // three corrected events
      send_event(2'b01, 5'd3);
      send_event(2'b01, 5'd7);
      send_event(2'b01, 5'd9);
      do_read(2'd0, 1, 1'b0, 2'b00, '0);
      do_read(2'd1, 1, 1'b0, 2'b00, '0);
      do_read(2'd2, 1, 1'b0, 2'b00, '0);
      do_read(2'd3, 1, 1'b0, 2'b00, '0);
      check("irq corr only", 32'(bus.irq_o), 32'(exp_irq()));

      // one uncorrectable event, irq one cycle after the counter
      do_clr();
      send_event(2'b10, 5'd5);
      check("irq not yet", 32'(bus.irq_o), 32'd0);
      @(negedge clk);
      check("irq after uncorr", 32'(bus.irq_o), 32'(exp_irq()));
      do_read(2'd3, 1, 1'b0, 2'b00, '0);
      do_read(2'd2, 1, 1'b0, 2'b00, '0);
      do_read(2'd3, 1, 1'b0, 2'b00, '0);
      do_read(2'd2, 1, 1'b0, 2'b00, '0);

      // clear then overflow with six corrected events
      do_clr();
      @(negedge clk);
      check("irq after clr", 32'(bus.irq_o), 32'd0);
      for (int i = 1; i <= 6; i++) send_event(2'b01, 5'(i));
      do_read(2'd2, 1, 1'b0, 2'b00, '0);
      check("irq ovf", 32'(bus.irq_o), 32'(exp_irq()));

      // full FIFO: pop and push on the same edge
      do_clr();
      for (int i = 1; i <= 4; i++) send_event(2'b01, 5'(i));
      do_read(2'd2, 1, 1'b0, 2'b00, '0);
      do_read(2'd3, 1, 1'b1, 2'b01, 5'd10);
      do_read(2'd2, 1, 1'b0, 2'b00, '0);
      for (int i = 0; i < 4; i++) do_read(2'd3, 1, 1'b0, 2'b00, '0);
      do_read(2'd2, 1, 1'b0, 2'b00, '0);
      do_read(2'd0, 1, 1'b0, 2'b00, '0);

      // event and clear in the same cycle
      send_event(2'b10, 5'd6);
      @(negedge clk);
      bus.event_valid_i = 1'b1;
      bus.result_i      = 2'b10;
      bus.register_i    = 5'd8;
      bus.clr_i         = 1'b1;
      @(negedge clk);
      bus.event_valid_i = 1'b0;
      bus.clr_i         = 1'b0;
      model_clear();
      do_read(2'd0, 1, 1'b0, 2'b00, '0);
      do_read(2'd1, 1, 1'b0, 2'b00, '0);
      do_read(2'd2, 1, 1'b0, 2'b00, '0);
      check("irq after clr+event", 32'(bus.irq_o), 32'd0);

      // held request gives one acknowledge
      send_event(2'b11, 5'd2);
      do_read(2'd1, 10, 1'b0, 2'b00, '0);

      // counter saturation
      do_clr();
      for (int i = 0; i < CMAX + 2; i++) send_event(2'b01, 5'(i));
      do_read(2'd0, 1, 1'b0, 2'b00, '0);
      do_read(2'd2, 1, 1'b0, 2'b00, '0);
      do_clr();
      for (int i = 0; i < CMAX + 2; i++) send_event(2'b10, 5'(i));
      do_read(2'd1, 1, 1'b0, 2'b00, '0);

      // reset asserted in the RESP cycle
      @(negedge clk);
      bus.rd_valid_i = 1'b1;
      bus.rd_adr_i   = 2'd1;
      @(posedge clk);
      #1;
      check("resp before reset ready", 32'(bus.rd_ready_o), 32'd1);
      check("resp before reset data", bus.rd_data_o, 32'(m_uncorr));
      rst_n = 1'b0;
      #1;
      check("reset mid-read ready", 32'(bus.rd_ready_o), 32'd0);
      check("reset mid-read data", bus.rd_data_o, 32'h0);
      check("reset mid-read irq", 32'(bus.irq_o), 32'd0);
      @(negedge clk);
      bus.rd_valid_i = 1'b0;
      @(negedge clk);
      check("reset held ready", 32'(bus.rd_ready_o), 32'd0);
      rst_n = 1'b1;
      model_clear();
      do_read(2'd1, 1, 1'b0, 2'b00, '0);
      do_read(2'd2, 1, 1'b0, 2'b00, '0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ecc_error_logger.md
ECC_ERROR_LOGGER -- requirements
Module: ecc_error_logger

Interface
REQ-001 Parameter REGDIRSIZE, default 5: register-index width.
REQ-002 Parameter COUNTERSIZE, default 32: error-counter width, at most 32.
REQ-003 Parameter FIFO_DEPTH, default 4: error-event FIFO entries, power of two.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
REQ-005 The block SHALL provide these further ports:
- event_valid_i  in  1  one-cycle strobe: a register-file access has completed.
- result_i  in  2  access result: 00 clean, 01 corrected, 10 uncorrectable, 11 treated as uncorrectable.
- register_i  in  REGDIRSIZE  register index of the access.
- clr_i  in  1  synchronous clear.
- rd_valid_i  in  1  status-read request.
- rd_adr_i  in  2  status-read address.
- rd_data_o  out  32  read data.
- rd_ready_o  out  1  one-cycle read acknowledge.
- irq_o  out  1  interrupt, level.

Function
REQ-006 On event_valid_i with result 01, the block SHALL increment corr_cnt; with result 10 or 11, it SHALL increment uncorr_cnt; with result 00, it SHALL change no state.
REQ-007 Both counters SHALL saturate at 2^COUNTERSIZE-1 and SHALL never wrap.
REQ-008 Every non-clean event SHALL push one FIFO entry {uncorr flag, register_i} in the cycle after the strobe.
REQ-009 If the FIFO is full and no pop occurs in the same cycle, the block SHALL drop the entry and set sticky ovf.
REQ-010 A push and a pop in the same cycle SHALL both complete and leave the FIFO count unchanged; this also applies when the FIFO is full, and ovf SHALL NOT be set.
REQ-011 The read FSM SHALL have three states:
- IDLE: rd_valid_i=1 latches rd_adr_i and moves to RESP.
- RESP: rd_ready_o=1 for exactly one cycle with rd_data_o valid, then moves to WAIT.
- WAIT: returns to IDLE once rd_valid_i=0.
REQ-012 Read latency SHALL be exactly one cycle from rd_valid_i sampled in IDLE to rd_ready_o.
REQ-013 One held request SHALL produce exactly one acknowledge.
REQ-014 The address map SHALL be:
- 0: corr_cnt, zero-extended.
- 1: uncorr_cnt, zero-extended.
- 2: status {ovf[31], count[15:8], full[1], empty[0]}, other bits 0.
- 3: FIFO head {uncorr[31], register[REGDIRSIZE-1:0]}, other bits 0; the head is popped in the RESP cycle.
REQ-015 An address-3 read while the FIFO is empty SHALL return 0, SHALL NOT pop, and SHALL NOT underflow.
REQ-016 rd_data_o SHALL be 0 in every state other than RESP.
REQ-017 clr_i SHALL zero both counters, empty the FIFO and clear ovf on the next edge.
REQ-018 clr_i SHALL take priority over an event in the same cycle; that event is discarded.
REQ-019 clr_i SHALL NOT affect the read FSM.

Reset
REQ-020 While rst_ni=0, the block SHALL immediately force:
- counters, FIFO pointers and ovf to 0;
- the FSM to IDLE;
- rd_ready_o, rd_data_o and irq_o to 0.
REQ-021 Reset asserted mid-read SHALL abort the read without an acknowledge.
REQ-022 Reset deassertion SHALL be synchronised to clk_i by the integrator; the block assumes a clean release.

Configuration
REQ-023 With macro ECC_LOG_IRQ_EN defined, irq_o SHALL be registered and equal (uncorr_cnt!=0) | ovf, updating one cycle after the cause and deasserting one cycle after clr_i.
REQ-024 Without ECC_LOG_IRQ_EN, irq_o SHALL be constant 0 and no interrupt logic shall be instantiated.

Verification
REQ-025 The bench SHALL cover:
- Three events with result 01 for registers 3, 7, 9, then read address 0 -> 0x00000003 with rd_ready_o high for 1 cycle.
- One event with result 10 for register 5, then read address 3 -> 0x80000005; then read address 2 -> empty=1.
- Six corrected events with FIFO_DEPTH=4, no reads -> status ovf=1, count=4, full=1; with ECC_LOG_IRQ_EN, irq_o=1.
- FIFO full, address-3 read RESP cycle coincides with a new event push -> count stays 4, ovf stays 0.
- event_valid_i and clr_i in the same cycle -> all counters 0, FIFO empty.
- rd_valid_i held high for 10 cycles -> exactly one rd_ready_o pulse; rst_ni low in RESP -> rd_ready_o=0 immediately.
